// File: rtl/set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache
// Purpose  : N-way set-associative data cache with tree PLRU replacement,
//            word write-through on hit and a multi-cycle flush engine.
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache #(
    parameter int ADDR_W   = 17,
    parameter int OFFSET_W = 1,
    parameter int INDEX_W  = 6,
    parameter int WAYS     = 2,
    parameter int DATA_W   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                address,
    input  logic                             read_en,
    input  logic                             fill_en,
    input  logic [DATA_W*(1<<OFFSET_W)-1:0]  fill_data,
    input  logic                             word_wr_en,
    input  logic [DATA_W-1:0]                word_wr_data,
    input  logic                             invalidate_en,
    input  logic                             flush_en,
    output logic [DATA_W-1:0]                read_data,
    output logic                             hit,
    output logic                             busy
);

    localparam int c_sets   = 1 << INDEX_W;
    localparam int c_words  = 1 << OFFSET_W;
    localparam int c_line_w = DATA_W * c_words;
    localparam int c_tag_w  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int c_way_w  = (WAYS == 4) ? 2 : 1;
    localparam int c_plru_w = (WAYS == 4) ? 3 : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    logic [WAYS-1:0]     r_valid [c_sets];
    logic [c_plru_w-1:0] r_plru  [c_sets];
    logic [c_tag_w-1:0]  r_tag   [c_sets][WAYS];
    logic [c_line_w-1:0] r_data  [c_sets][WAYS];
    state_t              r_state;
    logic [INDEX_W-1:0]  r_flush_cnt;
    logic                r_busy;

    logic [c_tag_w-1:0]  w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_hit_any;
    logic [c_way_w-1:0]  w_hit_way;
    logic                w_inv_any;
    logic [c_way_w-1:0]  w_inv_way;
    logic [c_line_w-1:0] w_line;
    logic [DATA_W-1:0]   w_word;
    logic [c_plru_w-1:0] w_plru_cur;
    logic [c_plru_w-1:0] w_plru_touch;
    logic [c_plru_w-1:0] w_plru_point;
    logic [c_way_w-1:0]  w_victim;
    logic [c_way_w-1:0]  w_fill_way;
    logic [c_way_w-1:0]  w_touch_way;
    logic                w_idle;
    logic                w_do_flush;
    logic                w_do_inv;
    logic                w_do_fill;
    logic                w_do_wr;
    logic                w_do_rd;

    assign w_tag    = address[ADDR_W-1 -: c_tag_w];
    assign w_index  = address[OFFSET_W +: INDEX_W];
    assign w_offset = address[OFFSET_W-1:0];

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[w_index][i] && (r_tag[w_index][i] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = c_way_w'(i);
            end
        end
        // Descending scan leaves the lowest-index invalid way selected.
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[w_index][i]) begin
                w_inv_any = 1'b1;
                w_inv_way = c_way_w'(i);
            end
        end
    end

    always_comb begin
        w_line = r_data[w_index][w_hit_way];
        w_word = '0;
        for (int k = 0; k < c_words; k++) begin
            if (w_offset == OFFSET_W'(k)) begin
                w_word = w_line[k*DATA_W +: DATA_W];
            end
        end
    end

    assign hit       = w_hit_any & ~r_busy;
    assign read_data = hit ? w_word : '0;
    assign busy      = r_busy;

    assign w_idle     = (r_state == S_IDLE);
    assign w_do_flush = w_idle & flush_en;
    assign w_do_inv   = w_idle & ~flush_en & invalidate_en & w_hit_any;
    assign w_do_fill  = w_idle & ~flush_en & ~invalidate_en & fill_en;
    assign w_do_wr    = w_idle & ~flush_en & ~invalidate_en & ~fill_en
                        & word_wr_en & w_hit_any;
    assign w_do_rd    = w_idle & ~flush_en & ~invalidate_en & ~fill_en
                        & ~word_wr_en & read_en & w_hit_any;

    assign w_fill_way  = w_hit_any ? w_hit_way : (w_inv_any ? w_inv_way : w_victim);
    assign w_touch_way = w_do_fill ? w_fill_way : w_hit_way;
    assign w_plru_cur  = r_plru[w_index];

    // Bit 0 is the root; bits 1 and 2 choose within the left and right pairs.
    generate
        if (WAYS == 4) begin : g_plru4
            always_comb begin
                w_victim = w_plru_cur[0] ? {1'b1, w_plru_cur[2]} : {1'b0, w_plru_cur[1]};
                w_plru_touch    = w_plru_cur;
                w_plru_touch[0] = ~w_touch_way[1];
                if (w_touch_way[1]) w_plru_touch[2] = ~w_touch_way[0];
                else                w_plru_touch[1] = ~w_touch_way[0];
                w_plru_point    = w_plru_cur;
                w_plru_point[0] = w_hit_way[1];
                if (w_hit_way[1]) w_plru_point[2] = w_hit_way[0];
                else              w_plru_point[1] = w_hit_way[0];
            end
        end else begin : g_plru2
            assign w_victim     = w_plru_cur;
            assign w_plru_touch = ~w_touch_way;
            assign w_plru_point = w_hit_way;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_sets; i++) begin
                r_valid[i] <= '0;
                r_plru[i]  <= '0;
            end
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_do_flush) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                        r_busy      <= 1'b1;
                    end else if (w_do_inv) begin
                        r_valid[w_index][w_hit_way] <= 1'b0;
                        r_plru[w_index]             <= w_plru_point;
                    end else if (w_do_fill) begin
                        r_valid[w_index][w_fill_way] <= 1'b1;
                        r_plru[w_index]              <= w_plru_touch;
                    end else if (w_do_wr || w_do_rd) begin
                        r_plru[w_index] <= w_plru_touch;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_flush_cnt] <= '0;
                    r_plru[r_flush_cnt]  <= '0;
                    r_flush_cnt          <= r_flush_cnt + 1'b1;
                    if (&r_flush_cnt) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage carries no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (w_do_fill) begin
            r_tag[w_index][w_fill_way]  <= w_tag;
            r_data[w_index][w_fill_way] <= fill_data;
        end else if (w_do_wr) begin
            for (int k = 0; k < c_words; k++) begin
                if (w_offset == OFFSET_W'(k)) begin
                    r_data[w_index][w_hit_way][k*DATA_W +: DATA_W] <= word_wr_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_cache
// Purpose  : Directed self-checking bench for set_assoc_cache (2-way and 4-way).
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache;

    logic        clk;
    logic        rst;
    logic [16:0] address;
    logic        read_en;
    logic        fill_en;
    logic [63:0] fill_data;
    logic        word_wr_en;
    logic [31:0] word_wr_data;
    logic        invalidate_en;
    logic        flush_en;
    logic [31:0] read_data;
    logic        hit;
    logic        busy;
    logic [31:0] read_data4;
    logic        hit4;
    logic        busy4;

    int n_total = 0;
    int n_bad   = 0;

    set_assoc_cache u_dut (
        .clk(clk), .rst(rst), .address(address), .read_en(read_en),
        .fill_en(fill_en), .fill_data(fill_data), .word_wr_en(word_wr_en),
        .word_wr_data(word_wr_data), .invalidate_en(invalidate_en),
        .flush_en(flush_en), .read_data(read_data), .hit(hit), .busy(busy)
    );

    // Shares stimulus with u_dut; only its outputs are checked in the 4-way steps.
    set_assoc_cache #(.WAYS(4)) u_dut4 (
        .clk(clk), .rst(rst), .address(address), .read_en(read_en),
        .fill_en(fill_en), .fill_data(fill_data), .word_wr_en(word_wr_en),
        .word_wr_data(word_wr_data), .invalidate_en(invalidate_en),
        .flush_en(flush_en), .read_data(read_data4), .hit(hit4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [16:0] a);
        address = a;
        #1;
    endtask

    task automatic do_fill(input logic [16:0] a, input logic [63:0] d);
        address = a; fill_data = d; fill_en = 1'b1;
        tick();
        fill_en = 1'b0;
    endtask

    task automatic do_read(input logic [16:0] a);
        address = a; read_en = 1'b1;
        tick();
        read_en = 1'b0;
    endtask

    task automatic do_wr(input logic [16:0] a, input logic [31:0] d);
        address = a; word_wr_data = d; word_wr_en = 1'b1;
        tick();
        word_wr_en = 1'b0;
    endtask

    task automatic do_inv(input logic [16:0] a);
        address = a; invalidate_en = 1'b1;
        tick();
        invalidate_en = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int hit_bad;
        logic [16:0] set_addr [5];
        set_addr = '{17'h0010, 17'h0020, 17'h0030, 17'h0040, 17'h0050};

        rst = 1'b1; address = '0; read_en = 1'b0; fill_en = 1'b0; fill_data = '0;
        word_wr_en = 1'b0; word_wr_data = '0; invalidate_en = 1'b0; flush_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        look(17'h00A5);
        check("rst_hit", {31'b0, hit}, 32'd0);
        check("rst_data", read_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_busy4", {31'b0, busy4}, 32'd0);

        // Basic fill and read of both words
        do_fill(17'h00A4, {32'h2222_2222, 32'h1111_1111});
        look(17'h00A5);
        check("fill_hit", {31'b0, hit}, 32'd1);
        check("fill_w1", read_data, 32'h2222_2222);
        look(17'h00A4);
        check("fill_w0", read_data, 32'h1111_1111);

        // 2-way replacement on index 2
        do_fill(17'h0004, {32'h0000_0001, 32'h0000_0000});
        do_fill(17'h0084, {32'h0000_0011, 32'h0000_0010});
        do_read(17'h0004);
        do_fill(17'h0104, {32'h0000_0021, 32'h0000_0020});
        look(17'h0004); check("r2_0004", {31'b0, hit}, 32'd1);
        look(17'h0104); check("r2_0104", {31'b0, hit}, 32'd1);
        look(17'h0084); check("r2_0084", {31'b0, hit}, 32'd0);
        check("r4_0084", {31'b0, hit4}, 32'd1);

        // 4-way tree order: state (b0,b1,b2) = (0,1,1), then way3 fill -> (0,1,0)
        do_fill(17'h0184, {32'h3333_0001, 32'h3333_0000});
        do_read(17'h0084);                         // -> (1,0,0): victim is way2
        do_fill(17'h0204, {32'h4444_0001, 32'h4444_0000});
        look(17'h0104); check("r4_0104_evict", {31'b0, hit4}, 32'd0);
        look(17'h0004); check("r4_0004", {31'b0, hit4}, 32'd1);
        look(17'h0204); check("r4_0204", {31'b0, hit4}, 32'd1);
        look(17'h0185); check("r4_0185_data", read_data4, 32'h3333_0001);
        do_fill(17'h0284, {32'h5555_0001, 32'h5555_0000});  // (0,0,1): victim way0
        look(17'h0004); check("r4_0004_evict", {31'b0, hit4}, 32'd0);
        look(17'h0284); check("r4_0284", {31'b0, hit4}, 32'd1);

        // Word write-through on hit, no allocate on miss
        do_fill(17'h0004, {32'hAAAA_AAAA, 32'hBBBB_BBBB});
        do_wr(17'h0005, 32'hDEAD_BEEF);
        look(17'h0005); check("wr_word", read_data, 32'hDEAD_BEEF);
        look(17'h0004); check("wr_other", read_data, 32'hBBBB_BBBB);
        do_wr(17'h0205, 32'h1234_5678);
        look(17'h0205); check("wr_miss_hit", {31'b0, hit}, 32'd0);
        look(17'h0005); check("wr_miss_keep", read_data, 32'hDEAD_BEEF);
        look(17'h0284); check("wr_miss_0284", read_data, 32'h5555_0000);
        look(17'h00A5); check("wr_miss_a5", read_data, 32'h2222_2222);

        // Invalidate on hit and refill into the freed way
        do_fill(17'h0084, {32'h0000_0011, 32'h0000_0010});
        do_inv(17'h0004);
        look(17'h0004); check("inv_0004", {31'b0, hit}, 32'd0);
        look(17'h0084); check("inv_0084", {31'b0, hit}, 32'd1);
        do_fill(17'h0304, {32'h6666_0001, 32'h6666_0000});
        look(17'h0304); check("inv_refill", read_data, 32'h6666_0000);
        look(17'h0084); check("inv_keep", {31'b0, hit}, 32'd1);

        // Flush: exactly 64 busy cycles, hit forced low, enables ignored
        for (int i = 0; i < 5; i++) do_fill(set_addr[i], {32'h7777_0000 + i, 32'h7000_0000});
        look(17'h0010); check("pre_flush", {31'b0, hit}, 32'd1);
        flush_en = 1'b1;
        tick();
        flush_en = 1'b0;
        busy_cnt = 0;
        hit_bad  = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cnt++;
            if (hit) hit_bad++;
            address  = (i == 5) ? 17'h0060 : 17'h0010;
            flush_en = (i == 5);
            fill_en  = (i == 5);
            tick();
            flush_en = 1'b0;
            fill_en  = 1'b0;
        end
        check("flush_busy_cycles", busy_cnt, 32'd64);
        check("flush_hit_low", hit_bad, 32'd0);
        hit_bad = 0;
        for (int i = 0; i < 5; i++) begin
            look(set_addr[i]);
            if (hit) hit_bad++;
        end
        check("flush_cleared", hit_bad, 32'd0);
        look(17'h0060); check("flush_fill_ignored", {31'b0, hit}, 32'd0);
        look(17'h00A5); check("flush_a5", {31'b0, hit}, 32'd0);

        // Reset in the 10th busy cycle
        do_fill(17'h0010, {32'h8888_0001, 32'h8888_0000});
        flush_en = 1'b1;
        tick();
        flush_en = 1'b0;
        repeat (9) tick();
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy_async", {31'b0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_busy_idle", {31'b0, busy}, 32'd0);
        look(17'h0010); check("rst_valid_clr", {31'b0, hit}, 32'd0);
        do_fill(17'h0010, {32'h9999_0001, 32'h9999_0000});
        look(17'h0011); check("rst_fsm_idle", read_data, 32'h9999_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
